// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: MUL decode fields, multiplier FSM encoding
// and the EXE command used to steer the multiplier result.
package arm_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned EXE_CMD_W = 4;

    localparam logic [MODE_W-1:0]    MUL_MODE   = 2'b00;
    localparam logic [OPCODE_W-1:0]  MUL_OPCODE = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_MUL    = 4'b1011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // ID-stage decode of a MUL instruction.
    function automatic logic is_mul(input logic [MODE_W-1:0] mode,
                                    input logic [OPCODE_W-1:0] opcode);
        return (mode == MUL_MODE) && (opcode == MUL_OPCODE);
    endfunction

endpackage

// File: rtl/mul_step_adder.sv
// One shift-add step: adds the multiplicand times a STEP-bit multiplier slice
// into the 2*WIDTH-bit accumulator.
module mul_step_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    mplier_slice,
    output logic [2*WIDTH-1:0] next_acc
);

    localparam int unsigned AW = 2 * WIDTH;

    // The full product never exceeds AW bits, so truncation here is exact.
    always_comb begin
        next_acc = acc + mcand * AW'(mplier_slice);
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EXE stage: launched from ID on a MUL,
// freezes IF/ID while running, pulses done with the full 2*WIDTH-bit product.
module mul_sequencer
    import arm_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hazard,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             freeze,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int unsigned AW     = 2 * WIDTH;
    localparam int unsigned NSTEPS = WIDTH / STEP;
    localparam int unsigned CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_c;
    logic [AW-1:0]    next_acc;

    mul_step_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_adder (
        .acc          (acc_q),
        .mcand        (mcand_q),
        .mplier_slice (mplier_q[STEP-1:0]),
        .next_acc     (next_acc)
    );

    assign accept_c = (state_q == MUL_IDLE) && start && !hazard && !flush;

    // Freeze already in the accept cycle so ID holds the MUL; released in DONE.
    assign freeze    = accept_c || (state_q == MUL_RUN);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;

        unique case (state_q)
            MUL_IDLE: begin
                if (accept_c) begin
                    mcand_d  = AW'(op_a);
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                acc_d    = next_acc;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    res_lo_d = next_acc[WIDTH-1:0];
                    res_hi_d = next_acc[AW-1:WIDTH];
                    state_d  = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase

        // A taken branch kills the operation and leaves the last result intact.
        if (flush) begin
            state_d  = MUL_IDLE;
            res_lo_d = res_lo_q;
            res_hi_d = res_hi_q;
        end

        busy_d = (state_d != MUL_IDLE);
        done_d = (state_d == MUL_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: default (STEP=1) and STEP=4 instances.
module tb_mul_sequencer;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start, hazard, flush;
    logic [31:0] op_a, op_b;
    logic        freeze, busy, done;
    logic [31:0] result_lo, result_hi;

    logic        start4, hazard4, flush4;
    logic [31:0] op_a4, op_b4;
    logic        freeze4, busy4, done4;
    logic [31:0] result_lo4, result_hi4;

    int          total;
    int          bad;
    int          cyc;
    logic [63:0] last0, last4;
    exp_t        q0[$];
    exp_t        q4[$];

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .hazard(hazard), .flush(flush),
        .op_a(op_a), .op_b(op_b), .freeze(freeze), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi)
    );

    mul_sequencer #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .hazard(hazard4), .flush(flush4),
        .op_a(op_a4), .op_b(op_b4), .freeze(freeze4), .busy(busy4), .done(done4),
        .result_lo(result_lo4), .result_hi(result_hi4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result monitors: every done pulse must match the oldest expected product and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected cyc=%0d got=%h want=none", cyc, {result_hi, result_lo});
            end else begin
                e = q0.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("done_result", {result_hi, result_lo}, e.prod);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done4_unexpected cyc=%0d got=%h want=none", cyc, {result_hi4, result_lo4});
            end else begin
                e = q4.pop_front();
                chk("done4_cycle", 64'(cyc), 64'(e.due));
                chk("done4_result", {result_hi4, result_lo4}, e.prod);
            end
        end
    end

    // Launch on the default instance; flush_at>0 flushes in that RUN cycle (1-based).
    task automatic launch0(input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input int haz);
        int          fz;
        logic [63:0] p;
        p      = 64'(a) * 64'(b);
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        hazard = (haz > 0);
        for (int i = 0; i < haz; i++) begin
            @(negedge clk);
            chk("hazard_freeze", 64'(freeze), 64'(0));
            chk("hazard_busy", 64'(busy), 64'(0));
            step();
        end
        hazard = 1'b0;
        if (flush_at <= 0) q0.push_back('{prod: p, due: cyc + 33});
        @(negedge clk);
        chk("accept_freeze", 64'(freeze), 64'(1));
        chk("accept_busy", 64'(busy), 64'(0));
        step();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        if (flush_at > 0) begin
            for (int i = 0; i < flush_at - 1; i++) step();
            flush = 1'b1;
            step();
            flush = 1'b0;
            @(negedge clk);
            chk("flush_busy", 64'(busy), 64'(0));
            chk("flush_keep_result", {result_hi, result_lo}, last0);
        end else begin
            fz = 0;
            for (int i = 0; i < 33; i++) begin
                @(negedge clk);
                fz += int'(freeze);
                step();
            end
            chk("run_freeze_cycles", 64'(fz), 64'(32));
            @(negedge clk);
            chk("idle_after_done", 64'(busy), 64'(0));
            last0 = p;
        end
        step();
    endtask

    task automatic launch4(input logic [31:0] a, input logic [31:0] b);
        int          fz;
        logic [63:0] p;
        p      = 64'(a) * 64'(b);
        op_a4  = a;
        op_b4  = b;
        start4 = 1'b1;
        q4.push_back('{prod: p, due: cyc + 9});
        step();
        start4 = 1'b0;
        op_a4  = $urandom;
        op_b4  = $urandom;
        fz = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            fz += int'(freeze4);
            step();
        end
        chk("run4_freeze_cycles", 64'(fz), 64'(8));
        @(negedge clk);
        chk("idle4_after_done", 64'(busy4), 64'(0));
        last4 = p;
        step();
    endtask

    initial begin
        int c0;
        total = 0;
        bad   = 0;
        last0 = '0;
        last4 = '0;
        rst = 1'b1;
        start = 1'b0; hazard = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        start4 = 1'b0; hazard4 = 1'b0; flush4 = 1'b0; op_a4 = '0; op_b4 = '0;
        step();
        step();
        @(negedge clk);
        chk("reset_freeze", 64'(freeze), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", {result_hi, result_lo}, 64'(0));
        chk("reset4_result", {result_hi4, result_lo4}, 64'(0));
        step();
        rst = 1'b0;
        step();

        launch0(32'd3, 32'd5, 0, 0);
        launch0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        launch0($urandom, $urandom, 0, 4);
        launch0(32'd7, 32'd9, 10, 0);
        launch0($urandom, $urandom, 32, 0);

        // Reset in the middle of RUN clears everything and emits no done.
        op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_freeze", 64'(freeze), 64'(0));
        chk("rst_mid_result", {result_hi, result_lo}, 64'(0));
        step();
        rst = 1'b0;
        last0 = '0;
        last4 = '0;
        step();

        // Held start: DONE ignores it, the following IDLE cycle relaunches.
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        c0 = cyc;
        q0.push_back('{prod: 64'd15, due: c0 + 33});
        q0.push_back('{prod: 64'd15, due: c0 + 67});
        for (int i = 0; i < 33; i++) step();
        @(negedge clk);
        chk("held_done_freeze", 64'(freeze), 64'(0));
        step();
        @(negedge clk);
        chk("held_relaunch_freeze", 64'(freeze), 64'(1));
        chk("held_relaunch_busy", 64'(busy), 64'(0));
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && cyc < c0 + 68; i++) step();
        @(negedge clk);
        chk("held_final_idle", 64'(busy), 64'(0));
        last0 = 64'd15;
        step();

        launch4(32'h1234_5678, 32'h9ABC_DEF0);
        launch4(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int n = 0; n < 12; n++) begin
            int fa;
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0;
            launch0($urandom, $urandom, fa, int'($urandom_range(0, 2)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
        for (int n = 0; n < 6; n++) launch4($urandom, $urandom);

        step();
        step();
        chk("queue0_drained", 64'(q0.size()), 64'(0));
        chk("queue4_drained", 64'(q4.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
